// File: rtl/hsv_pkg.sv
// rtl/hsv_pkg.sv - shared fp32 constants, stage-A payload type and helpers for the HSV datapath
//
// Purpose : fp32 field widths, hue offset constants, aligned-operand payload
//           struct and a leading-zero counter used by the hue adder.
// Ports   : none (package)
package hsv_pkg;

   localparam int FP32_SGN_W = 1;
   localparam int FP32_EXP_W = 8;
   localparam int FP32_MAN_W = 23;

   // Aligned mantissa: hidden bit + 23 fraction bits + 3 guard bits.
   localparam int ALN_W = 1 + FP32_MAN_W + 3;

   localparam logic [31:0] HUE_OFF_0   = 32'h0000_0000;
   localparam logic [31:0] HUE_OFF_85  = 32'h42AA_0000;
   localparam logic [31:0] HUE_OFF_171 = 32'h432B_0000;
   localparam logic [31:0] FP32_QNAN   = 32'h7FC0_0000;
   localparam logic [31:0] FP32_ZERO   = 32'h0000_0000;

   typedef struct packed {
      logic                  sign;
      logic [FP32_EXP_W-1:0] exp;
      logic [ALN_W-1:0]      mant_big;
      logic [ALN_W-1:0]      mant_small;
      logic                  eff_sub;
      logic                  is_nan;
   } align_t;

   // Leading zeros of a 28-bit value; 28 when the value is zero.
   function automatic logic [4:0] lzc28(input logic [27:0] v);
      logic [4:0] n;
      n = 5'd28;
      for (int i = 0; i < 28; i++) begin
         if (v[i]) n = 5'(27 - i);
      end
      return n;
   endfunction

endpackage

// File: rtl/fp32_addsub_pipe.sv
// rtl/fp32_addsub_pipe.sv - two-stage fp32 adder with per-stage enables and meta pass-through
//
// Purpose : stage A aligns operands (swap to |big| >= |small|, shift small),
//           stage B adds/subtracts, normalises and truncates.
// Ports   : clk, rst        clock, async active-high reset
//           en_a_i, en_b_i  load enables for stage A / stage B registers
//           a_i, b_i        fp32 operands
//           meta_i          META_W bits carried alongside the operands
//           res_o           fp32 result (stage B register)
//           meta_o          meta aligned with res_o
module fp32_addsub_pipe
   import hsv_pkg::*;
#(
   parameter int META_W = 65
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en_a_i,
   input  logic              en_b_i,
   input  logic [31:0]       a_i,
   input  logic [31:0]       b_i,
   input  logic [META_W-1:0] meta_i,
   output logic [31:0]       res_o,
   output logic [META_W-1:0] meta_o
);

   align_t            aq_d, aq_q;
   logic [META_W-1:0] meta_a_q, meta_b_q;
   logic [31:0]       res_d, res_q;

   // ---------------- stage A: align ----------------
   logic [30:0]           mag_a, mag_b, mag_big, mag_small;
   logic                  swap;
   logic [FP32_EXP_W-1:0] exp_diff;
   logic [ALN_W-1:0]      m_big, m_small;

   always_comb begin
      // Exponent 0 (zero or denormal) is flushed to a zero magnitude.
      mag_a     = (a_i[30:23] == 8'd0) ? 31'd0 : a_i[30:0];
      mag_b     = (b_i[30:23] == 8'd0) ? 31'd0 : b_i[30:0];
      swap      = (mag_b > mag_a);
      mag_big   = swap ? mag_b : mag_a;
      mag_small = swap ? mag_a : mag_b;
      m_big     = (mag_big[30:23] == 8'd0)   ? '0 : {1'b1, mag_big[22:0], 3'b000};
      m_small   = (mag_small[30:23] == 8'd0) ? '0 : {1'b1, mag_small[22:0], 3'b000};
      exp_diff  = mag_big[30:23] - mag_small[30:23];

      aq_d            = '0;
      aq_d.sign       = swap ? b_i[31] : a_i[31];
      aq_d.exp        = mag_big[30:23];
      aq_d.mant_big   = m_big;
      aq_d.mant_small = (exp_diff >= 8'd26) ? '0 : (m_small >> exp_diff);
      aq_d.eff_sub    = a_i[31] ^ b_i[31];
      aq_d.is_nan     = (a_i[30:23] == 8'hFF) || (b_i[30:23] == 8'hFF);
   end

   // ---------------- stage B: add, normalise ----------------
   logic [27:0]       sum, norm;
   logic [4:0]        lz;
   logic signed [9:0] exp_n;

   always_comb begin
      // |big| >= |small| so the subtraction never goes negative.
      sum   = aq_q.eff_sub ? ({1'b0, aq_q.mant_big} - {1'b0, aq_q.mant_small})
                           : ({1'b0, aq_q.mant_big} + {1'b0, aq_q.mant_small});
      lz    = lzc28(sum);
      norm  = sum << lz;
      // Hidden bit sits at bit 26 un-normalised; a carry into bit 27 gives lz=0.
      exp_n = signed'({2'b00, aq_q.exp}) + 10'sd1 - signed'({5'b00000, lz});

      res_d = {aq_q.sign, exp_n[7:0], norm[26:4]};
      if (aq_q.is_nan) begin
         res_d = FP32_QNAN;
      end else if (sum == 28'd0) begin
         res_d = FP32_ZERO;
      end else if (exp_n >= 10'sd255) begin
         res_d = {aq_q.sign, 8'hFF, 23'd0};
      end else if (exp_n <= 10'sd0) begin
         res_d = {aq_q.sign, 31'd0};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         aq_q     <= '0;
         meta_a_q <= '0;
         res_q    <= '0;
         meta_b_q <= '0;
      end else begin
         if (en_a_i) begin
            aq_q     <= aq_d;
            meta_a_q <= meta_i;
         end
         if (en_b_i) begin
            res_q    <= res_d;
            meta_b_q <= meta_a_q;
         end
      end
   end

   assign res_o  = res_q;
   assign meta_o = meta_b_q;

endmodule

// File: rtl/hue_offset_stage.sv
// rtl/hue_offset_stage.sv - selects max-channel hue term, adds its offset, handshaked 2-deep pipe
//
// Purpose : priority select (R > G > B) of hue term and offset, fp32 add in a
//           two-stage pipe, sideband and sel_err carried with each beat.
// Ports   : clk, rst                  clock, async active-high reset
//           in_valid / in_ready       input handshake
//           t_r, t_g, t_b             candidate hue terms (fp32)
//           max_r, max_g, max_b       one-hot max-channel flags
//           side_in                   SIDE_W pass-through sideband
//           out_valid / out_ready     output handshake
//           hue, side_out, sel_err    result, aligned sideband, no-flag error
module hue_offset_stage
   import hsv_pkg::*;
#(
   parameter logic [31:0] OFFSET_R = HUE_OFF_0,
   parameter logic [31:0] OFFSET_G = HUE_OFF_85,
   parameter logic [31:0] OFFSET_B = HUE_OFF_171,
   parameter int          SIDE_W   = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [31:0]       t_r,
   input  logic [31:0]       t_g,
   input  logic [31:0]       t_b,
   input  logic              max_r,
   input  logic              max_g,
   input  logic              max_b,
   input  logic [SIDE_W-1:0] side_in,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [31:0]       hue,
   output logic [SIDE_W-1:0] side_out,
   output logic              sel_err
);

   logic [31:0]     sel_term, sel_off;
   logic            sel_err_c;
   logic            a_valid_d, a_valid_q, b_valid_d, b_valid_q;
   logic            a_adv, b_adv;
   logic [SIDE_W:0] meta_out;

   // With no flag set both operands are +0 so the adder yields +0.
   always_comb begin
      sel_term  = FP32_ZERO;
      sel_off   = FP32_ZERO;
      sel_err_c = 1'b0;
      if (max_r) begin
         sel_term = t_r;
         sel_off  = OFFSET_R;
      end else if (max_g) begin
         sel_term = t_g;
         sel_off  = OFFSET_G;
      end else if (max_b) begin
         sel_term = t_b;
         sel_off  = OFFSET_B;
      end else begin
         sel_err_c = 1'b1;
      end
   end

   always_comb begin
      b_adv     = !b_valid_q || out_ready;
      a_adv     = !a_valid_q || b_adv;
      a_valid_d = a_adv ? in_valid  : a_valid_q;
      b_valid_d = b_adv ? a_valid_q : b_valid_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_valid_q <= 1'b0;
         b_valid_q <= 1'b0;
      end else begin
         a_valid_q <= a_valid_d;
         b_valid_q <= b_valid_d;
      end
   end

   fp32_addsub_pipe #(
      .META_W (SIDE_W + 1)
   ) u_add (
      .clk    (clk),
      .rst    (rst),
      .en_a_i (a_adv && in_valid),
      .en_b_i (b_adv && a_valid_q),
      .a_i    (sel_term),
      .b_i    (sel_off),
      .meta_i ({sel_err_c, side_in}),
      .res_o  (hue),
      .meta_o (meta_out)
   );

   assign in_ready  = a_adv;
   assign out_valid = b_valid_q;
   assign sel_err   = meta_out[SIDE_W];
   assign side_out  = meta_out[SIDE_W-1:0];

endmodule
